v_lane_seq: RTL

Operand sequencer and result collector that sits directly upstream and downstream of the 4-lane ALU/MUL array. It accepts one vector instruction with a register group of up to four 128-bit operand registers per source. It slices the group into beats according to LMUL and the configured lane count, and streams the beats into the lanes. It then reassembles the returned ALU and MUL results into per-register result buffers and pulses `done`.

---
 rtl/v_pkg.sv | 37 +++
 rtl/v_beat_mux.sv | 30 +++
 rtl/v_lane_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/v_pkg.sv
// Shared types, constants and beat-count helper for the vector lane sequencer.
// Decodes LMUL and lane-count encodings into group sizes and beats.
package v_pkg;

  localparam int REG_W = 128;
  localparam int SLOTS = 4;

  typedef enum logic [2:0] {
    LMUL_1 = 3'b000,
    LMUL_2 = 3'b001,
    LMUL_4 = 3'b010
  } lmul_e;

  typedef enum logic [1:0] {
    LANES_4  = 2'b00,
    LANES_8  = 2'b01,
    LANES_16 = 2'b10
  } lanes_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic logic cfg_legal(input logic [2:0] lmul, input logic [1:0] lanes);
    return (lmul <= 3'b010) && (lanes != 2'b11);
  endfunction

  // Both counts are powers of two, so the ceiling divide reduces to a shift.
  function automatic logic [2:0] num_beats(input logic [2:0] lmul, input logic [1:0] lanes);
    if (lmul > {1'b0, lanes}) num_beats = 3'd1 << (lmul - {1'b0, lanes});
    else                      num_beats = 3'd1;
  endfunction

endpackage

// File: rtl/v_beat_mux.sv
// Maps a beat index and configuration to per-slot enables and register indices.
// Used by both the operand issue path and the result writeback path.
module v_beat_mux
  import v_pkg::*;
(
  input  logic [1:0]             i_beat,
  input  lmul_e                  i_lmul,
  input  lanes_e                 i_lanes,
  output logic [SLOTS-1:0]       o_slot_en,
  output logic [SLOTS-1:0][1:0]  o_reg_idx
);

  logic [4:0] w_spb;
  logic [4:0] w_nregs;
  logic [4:0] w_base;
  logic [4:0] w_reg [SLOTS];

  assign w_spb   = 5'd1 << i_lanes;
  assign w_nregs = 5'd1 << i_lmul;
  assign w_base  = {3'b000, i_beat} << i_lanes;

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      w_reg[s]     = w_base + 5'(s);
      o_slot_en[s] = (5'(s) < w_spb) && (w_reg[s] < w_nregs);
      o_reg_idx[s] = w_reg[s][1:0];
    end
  end

endmodule

// File: rtl/v_lane_seq.sv
// Operand sequencer and result collector for the 4-lane ALU/MUL array.
// Streams a register group into lane beats and reassembles returned results.
module v_lane_seq #(
  parameter int REG_W = v_pkg::REG_W,
  parameter int SLOTS = v_pkg::SLOTS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [5:0]             op_instr_alu,
  input  logic [5:0]             op_instr_mul,
  input  logic [2:0]             vsew,
  input  logic [2:0]             lmul,
  input  logic [1:0]             lanes,
  input  logic [REG_W-1:0]       op_A_1,
  input  logic [REG_W-1:0]       op_A_2,
  input  logic [REG_W-1:0]       op_A_3,
  input  logic [REG_W-1:0]       op_A_4,
  input  logic [REG_W-1:0]       op_B_1,
  input  logic [REG_W-1:0]       op_B_2,
  input  logic [REG_W-1:0]       op_B_3,
  input  logic [REG_W-1:0]       op_B_4,
  output logic                   lane_valid,
  output logic [SLOTS-1:0]       lane_slot_en,
  output logic [SLOTS*REG_W-1:0] lane_op_A,
  output logic [SLOTS*REG_W-1:0] lane_op_B,
  output logic [5:0]             lane_instr_alu,
  output logic [5:0]             lane_instr_mul,
  output logic [2:0]             lane_vsew,
  input  logic                   lane_res_valid,
  input  logic [SLOTS*REG_W-1:0] lane_res_valu,
  input  logic [SLOTS*REG_W-1:0] lane_res_vmul,
  output logic [REG_W-1:0]       result_valu_1,
  output logic [REG_W-1:0]       result_valu_2,
  output logic [REG_W-1:0]       result_valu_3,
  output logic [REG_W-1:0]       result_valu_4,
  output logic [REG_W-1:0]       result_vmul_1,
  output logic [REG_W-1:0]       result_vmul_2,
  output logic [REG_W-1:0]       result_vmul_3,
  output logic [REG_W-1:0]       result_vmul_4,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  import v_pkg::*;

  state_e           r_state;
  state_e           w_next;
  logic [5:0]       r_instr_alu;
  logic [5:0]       r_instr_mul;
  logic [2:0]       r_vsew;
  lmul_e            r_lmul;
  lanes_e           r_lanes;
  logic [2:0]       r_nbeats;
  logic [2:0]       r_issue_cnt;
  logic [2:0]       r_ret_cnt;
  logic             r_err;
  logic [REG_W-1:0] r_op_a     [4];
  logic [REG_W-1:0] r_op_b     [4];
  logic [REG_W-1:0] r_res_valu [4];
  logic [REG_W-1:0] r_res_vmul [4];

  logic                  w_legal;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [2:0]            w_ret_next;
  logic [SLOTS-1:0]      w_iss_en;
  logic [SLOTS-1:0][1:0] w_iss_idx;
  logic [SLOTS-1:0]      w_ret_en;
  logic [SLOTS-1:0][1:0] w_ret_idx;

  v_beat_mux u_iss_mux (
    .i_beat    (r_issue_cnt[1:0]),
    .i_lmul    (r_lmul),
    .i_lanes   (r_lanes),
    .o_slot_en (w_iss_en),
    .o_reg_idx (w_iss_idx)
  );

  v_beat_mux u_ret_mux (
    .i_beat    (r_ret_cnt[1:0]),
    .i_lmul    (r_lmul),
    .i_lanes   (r_lanes),
    .o_slot_en (w_ret_en),
    .o_reg_idx (w_ret_idx)
  );

  // Results are in order and may start arriving before the last beat is issued.
  assign w_legal     = cfg_legal(lmul, lanes);
  assign w_accept    = lane_res_valid && (r_state == ST_ISSUE || r_state == ST_DRAIN) &&
                       (r_ret_cnt < r_nbeats);
  assign w_ret_next  = r_ret_cnt + {2'b00, w_accept};
  assign w_last_beat = (r_issue_cnt == r_nbeats - 3'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (issue_valid && w_legal) w_next = ST_ISSUE;
      ST_ISSUE: if (w_last_beat) w_next = (w_ret_next == r_nbeats) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (w_ret_next == r_nbeats) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_alu <= '0;
      r_instr_mul <= '0;
      r_vsew      <= '0;
      r_lmul      <= LMUL_1;
      r_lanes     <= LANES_4;
      r_nbeats    <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_err       <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        r_op_a[r]     <= '0;
        r_op_b[r]     <= '0;
        r_res_valu[r] <= '0;
        r_res_vmul[r] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      // An illegal configuration is consumed here and only reported, never executed.
      if (r_state == ST_IDLE && issue_valid) begin
        if (w_legal) begin
          r_instr_alu <= op_instr_alu;
          r_instr_mul <= op_instr_mul;
          r_vsew      <= vsew;
          r_lmul      <= lmul_e'(lmul);
          r_lanes     <= lanes_e'(lanes);
          r_nbeats    <= num_beats(lmul, lanes);
          r_issue_cnt <= '0;
          r_ret_cnt   <= '0;
          r_op_a[0]   <= op_A_1;
          r_op_a[1]   <= op_A_2;
          r_op_a[2]   <= op_A_3;
          r_op_a[3]   <= op_A_4;
          r_op_b[0]   <= op_B_1;
          r_op_b[1]   <= op_B_2;
          r_op_b[2]   <= op_B_3;
          r_op_b[3]   <= op_B_4;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == ST_ISSUE) r_issue_cnt <= r_issue_cnt + 3'd1;
      if (w_accept) begin
        r_ret_cnt <= w_ret_next;
        for (int r = 0; r < 4; r++) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (w_ret_en[s] && w_ret_idx[s] == 2'(r)) begin
              r_res_valu[r] <= lane_res_valu[s*REG_W +: REG_W];
              r_res_vmul[r] <= lane_res_vmul[s*REG_W +: REG_W];
            end
          end
        end
      end
    end
  end

  always_comb begin
    lane_slot_en = '0;
    lane_op_A    = '0;
    lane_op_B    = '0;
    if (r_state == ST_ISSUE) begin
      lane_slot_en = w_iss_en;
      for (int s = 0; s < SLOTS; s++) begin
        if (w_iss_en[s]) begin
          lane_op_A[s*REG_W +: REG_W] = r_op_a[w_iss_idx[s]];
          lane_op_B[s*REG_W +: REG_W] = r_op_b[w_iss_idx[s]];
        end
      end
    end
  end

  assign issue_ready    = (r_state == ST_IDLE);
  assign lane_valid     = (r_state == ST_ISSUE);
  assign busy           = (r_state != ST_IDLE);
  assign done           = (r_state == ST_DONE);
  assign err            = r_err;
  assign lane_instr_alu = r_instr_alu;
  assign lane_instr_mul = r_instr_mul;
  assign lane_vsew      = r_vsew;

  assign result_valu_1 = r_res_valu[0];
  assign result_valu_2 = r_res_valu[1];
  assign result_valu_3 = r_res_valu[2];
  assign result_valu_4 = r_res_valu[3];
  assign result_vmul_1 = r_res_vmul[0];
  assign result_vmul_2 = r_res_vmul[1];
  assign result_vmul_3 = r_res_vmul[2];
  assign result_vmul_4 = r_res_vmul[3];

endmodule
